// File: rtl/sample_pack_fifo.sv
// Packs pairs of 16-bit SPI samples into 32-bit words, with the first sample in [31:16].
// The words are buffered in a circular FIFO that the block pipe-out endpoint drains.
module sample_pack_fifo #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  sample_valid,
    input  logic [15:0]           sample_data,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  block_ready,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  empty,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] BLOCK_COUNT = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);

    typedef enum logic {
        HALF0,
        HALF1
    } pack_state_e;

    pack_state_e state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic        push_req;
    logic [31:0] push_word;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           rd_data_q;
    logic                  push_ok, pop_ok;

    logic [31:0] mem [DEPTH];

    // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HALF0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        push_req  = 1'b0;
        push_word = {hi_q, sample_data};
        if (clear) begin
            state_d = HALF0;
        end else begin
            unique case (state_q)
                HALF0: begin
                    if (sample_valid) begin
                        hi_d    = sample_data;
                        state_d = HALF1;
                    end
                end
                HALF1: begin
                    if (sample_valid) begin
                        push_req = 1'b1;
                        state_d  = HALF0;
                    end
                end
                default: state_d = HALF0;
            endcase
        end
    end

    // When full, a simultaneous pop frees the slot, so the push still succeeds.
    always_comb begin
        pop_ok     = rd_en && (count_q != '0) && !clear;
        push_ok    = push_req && ((count_q != FULL_COUNT) || pop_ok);
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop_ok);
        overflow_d = overflow_q | (push_req & ~push_ok);
        count_d    = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; the count guarantees that stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // A clear leaves the last popped word on rd_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (pop_ok) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data     = rd_data_q;
    assign fill_count  = count_q;
    assign empty       = (count_q == '0);
    assign block_ready = (count_q >= BLOCK_COUNT);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sample_pack_fifo.sv
// Self-checking bench for sample_pack_fifo: a queue-based reference model is compared every
// cycle, and directed scenarios add hand-computed literal expectations.
module tb_sample_pack_fifo;

    localparam int DL    = 3;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset, clear, sample_valid, rd_en;
    logic [15:0]   sample_data;
    logic [31:0]   rd_data;
    logic          block_ready, empty, overflow;
    logic [DL:0]   fill_count;

    always #5 clk = ~clk;

    sample_pack_fifo #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .block_ready  (block_ready),
        .fill_count   (fill_count),
        .empty        (empty),
        .overflow     (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the pending half-sample.
    logic [31:0] mq[$];
    bit          m_pend;
    logic [15:0] m_hi;
    bit          m_ovf;
    logic [31:0] m_rd;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset || clear) begin
            mq.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            if (reset) m_rd = '0;
        end else begin
            if (rd_en && mq.size() > 0) m_rd = mq.pop_front();
            if (sample_valid) begin
                if (!m_pend) begin
                    m_pend = 1'b1;
                    m_hi   = sample_data;
                end else begin
                    m_pend = 1'b0;
                    if (mq.size() < DEPTH) mq.push_back({m_hi, sample_data});
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_fill_count", 32'(fill_count), 32'(mq.size()));
            check("model_empty", 32'(empty), 32'(mq.size() == 0));
            check("model_block_ready", 32'(block_ready), 32'(mq.size() >= BW));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
            check("model_rd_data", rd_data, m_rd);
            check("fill_le_depth", 32'(fill_count <= DEPTH), 32'd1);
        end
    end

    task automatic step(input bit sv, input logic [15:0] sd, input bit re, input bit clr);
        sample_valid = sv;
        sample_data  = sd;
        rd_en        = re;
        clear        = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        rd_en        = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit re_first, input bit re_second);
        step(1'b1, w[31:16], re_first, 1'b0);
        step(1'b1, w[15:0], re_second, 1'b0);
    endtask

    function automatic logic [31:0] wd(input int i);
        logic [15:0] k;
        k = 16'(i);
        return {16'hA000 + k, 16'hB000 + k};
    endfunction

    initial begin
        reset = 1'b1; clear = 1'b0; sample_valid = 1'b0; rd_en = 1'b0; sample_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_fill", 32'(fill_count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_block_ready", 32'(block_ready), 32'd0);

        // Single pair, then one pop.
        push_word(32'h1111_2222, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t1_fill", 32'(fill_count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t1_rd_data", rd_data, 32'h1111_2222);
        check("t1_empty", 32'(empty), 32'd1);

        // block_ready threshold.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push_word(wd(i), 1'b0, 1'b0);
        check("t2_br_3", 32'(block_ready), 32'd0);
        push_word(wd(3), 1'b0, 1'b0);
        check("t2_br_4", 32'(block_ready), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t2_br_pop", 32'(block_ready), 32'd0);

        // Overflow: nine words into eight slots.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) push_word(wd(i), 1'b0, 1'b0);
        check("t3_fill", 32'(fill_count), 32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("t3_read%0d", i), rd_data, wd(i));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("t3_no_word8", rd_data, wd(7));
        check("t3_empty", 32'(empty), 32'd1);

        // Push and pop together while full.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 20; i < 28; i++) push_word(wd(i), 1'b0, 1'b0);
        check("t4_full", 32'(fill_count), 32'd8);
        push_word(wd(28), 1'b0, 1'b1);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_fill", 32'(fill_count), 32'd8);
        check("t4_pop_same", rd_data, wd(20));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t4_new_word_8th", rd_data, wd(28));

        // Interleaved traffic across the pointer wrap.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 5; i++) push_word(wd(40 + i), (i % 3) != 0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t5_last", rd_data, wd(52));
        check("t5_empty", 32'(empty), 32'd1);

        // Clear with pending odd sample and a simultaneous rd_en.
        for (int i = 60; i < 63; i++) push_word(wd(i), 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("t6_fill", 32'(fill_count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_rd_hold", rd_data, wd(52));
        push_word(32'hCAFE_BEEF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t6_repack", rd_data, 32'hCAFE_BEEF);

        step(1'b0, '0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
